// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the pe_array tile sequencer.
//   state_t  : sequencer states, one per phase of a tile
//   STATE_W  : encoded width of state_t
package pe_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    BIAS    = 3'd1,
    COMPUTE = 3'd2,
    FLUSH   = 3'd3,
    COMMIT  = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/pe_ctrl_cnt.sv
// Loadable down-counter with zero flag.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears count)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one
//   zero       : count is zero
module pe_ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile-level sequencer for the pe_array datapath.
// One tile: bias load, activation/weight beats, MAC flush, psum commit,
// then N_PEs results shifted out under backpressure.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, cfg_*        : tile start pulse and per-tile configuration
//   ia_valid/ia_ready   : activation beat handshake
//   wgt_valid/wgt_ready : weight word handshake
//   psum_valid/ready    : result handshake on pe_array psum_out
//   wea_reg1/2, sel_pe_reg, load_bias, load_psum, shift, rst_pe_relu_reg,
//   if_relu, act_sparsity_en, ia_sign : pe_array control
//   busy, done          : status
// Optional build macro PE_CTRL_PERF_EN adds perf_cycles / perf_stall.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int N_PEs      = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int PIPE_LAT   = 2,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [N_PEs-1:0]     cfg_pe_mask,
  input  logic                 cfg_relu,
  input  logic                 cfg_sparsity,
  input  logic                 cfg_ia_sign,
  input  logic                 ia_valid,
  input  logic                 wgt_valid,
  output logic                 ia_ready,
  output logic                 wgt_ready,
  input  logic                 psum_ready,
  output logic                 psum_valid,
  output logic [N_PEs-1:0]     wea_reg1,
  output logic [N_PEs-1:0]     wea_reg2,
  output logic                 sel_pe_reg,
  output logic                 load_bias,
  output logic                 load_psum,
  output logic                 shift,
  output logic                 rst_pe_relu_reg,
  output logic                 if_relu,
  output logic                 act_sparsity_en,
  output logic                 ia_sign,
  output logic                 busy,
  output logic                 done
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stall
`endif
);

  localparam int FLUSH_W = $clog2(PIPE_LAT + 1);
  localparam int DRAIN_W = $clog2(N_PEs + 1);

  // The flush counter cannot express a zero-cycle wait, and psum_valid
  // only qualifies a real result bus.
  if (PIPE_LAT < 1 || PSUM_WIDTH < 1) begin : g_bad_param
    $error("pe_array_ctrl: PIPE_LAT and PSUM_WIDTH must be >= 1");
  end

  state_t           state;
  logic [N_PEs-1:0] mask;
  logic             len_zero;
  logic             beat;
  logic             beat_last;
  logic             flush_last;
  logic             drain_last;

  assign beat  = (state == COMPUTE) && ia_valid && wgt_valid;
  assign shift = (state == DRAIN) && psum_ready;

  // Counters hold N-1 so the zero flag marks the final beat/cycle/shift.
  // Each reloads while its phase is inactive, so entry needs no extra state.
  pe_ctrl_cnt #(.W(LEN_WIDTH)) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == IDLE),
    .load_val (cfg_len - LEN_WIDTH'(1)),
    .dec      (beat),
    .zero     (beat_last)
  );

  pe_ctrl_cnt #(.W(FLUSH_W)) u_flush_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state != FLUSH),
    .load_val (FLUSH_W'(PIPE_LAT - 1)),
    .dec      (state == FLUSH),
    .zero     (flush_last)
  );

  pe_ctrl_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state != DRAIN),
    .load_val (DRAIN_W'(N_PEs - 1)),
    .dec      (shift),
    .zero     (drain_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sel_pe_reg      <= 1'b0;
      mask            <= '0;
      len_zero        <= 1'b0;
      if_relu         <= 1'b0;
      act_sparsity_en <= 1'b0;
      ia_sign         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask            <= cfg_pe_mask;
            len_zero        <= (cfg_len == '0);
            if_relu         <= cfg_relu;
            act_sparsity_en <= cfg_sparsity;
            ia_sign         <= cfg_ia_sign;
            state           <= BIAS;
          end
        end
        BIAS:    state <= len_zero ? FLUSH : COMPUTE;
        COMPUTE: if (beat && beat_last) state <= FLUSH;
        FLUSH:   if (flush_last) state <= COMMIT;
        COMMIT:  state <= DRAIN;
        DRAIN:   if (shift && drain_last) state <= DONE;
        DONE: begin
          sel_pe_reg <= ~sel_pe_reg;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ia_ready        = beat;
  assign wgt_ready       = beat;
  // sel_pe_reg=0 computes into bank 1 while bank 2 is the active one.
  assign wea_reg1        = (beat && !sel_pe_reg) ? mask : '0;
  assign wea_reg2        = (beat &&  sel_pe_reg) ? mask : '0;
  assign load_bias       = (state == BIAS);
  assign load_psum       = (state == COMMIT);
  assign psum_valid      = (state == DRAIN);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign rst_pe_relu_reg = (state == DONE);

`ifdef PE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy)
        perf_cycles <= perf_cycles + 32'd1;
      if ((state == COMPUTE && !beat) || (state == DRAIN && !psum_ready))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
